// File: rtl/muldiv_if.sv
// Request/response bundle between the EX stage and the iterative RV32M multiply/divide unit.
interface muldiv_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_reg;
  logic [XLEN-1:0] rs2_reg;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, flush, funct3, rs1_reg, rs2_reg,
    input  busy, done, result
  );

  modport slave (
    input  start, flush, funct3, rs1_reg, rs2_reg,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide: shift-add multiply, restoring divide,
// one bit per cycle on operand magnitudes with a sign fix-up on the final cycle.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic    clk,
  input  logic    rst_n,
  muldiv_if.slave bus
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam int unsigned PW = 2 * XLEN;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;

  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic            sa_q, sa_d;
  logic            sb_q, sb_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] res_q, res_d;

  // Request decode: which operands are signed, their magnitudes, and early-out cases.
  logic            a_signed, b_signed;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs;
  logic            is_div_in;
  logic            div_zero, div_ovf;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (bus.funct3)
      OP_MULH, OP_DIV, OP_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      OP_MULHSU: a_signed = 1'b1;
      default: ;
    endcase
  end

  assign a_neg     = a_signed & bus.rs1_reg[XLEN-1];
  assign b_neg     = b_signed & bus.rs2_reg[XLEN-1];
  assign a_abs     = a_neg ? (~bus.rs1_reg + XLEN'(1)) : bus.rs1_reg;
  assign b_abs     = b_neg ? (~bus.rs2_reg + XLEN'(1)) : bus.rs2_reg;
  assign is_div_in = bus.funct3[2];
  assign div_zero  = is_div_in & (bus.rs2_reg == '0);
  assign div_ovf   = is_div_in & ~bus.funct3[0] & (bus.rs1_reg == SMIN) & (&bus.rs2_reg);

  // Multiply step: multiplier sits in the low half and shifts out as the product shifts in.
  logic [XLEN:0] mul_sum;
  logic [PW-1:0] mul_step;

  assign mul_sum  = {1'b0, acc_q[PW-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_step = {mul_sum, acc_q[XLEN-1:1]};

  // Divide step: remainder in the high half, dividend bits shift up into it, quotient fills the low half.
  logic [XLEN:0] rem_sh, rem_diff;
  logic [PW-1:0] div_step;

  assign rem_sh   = acc_q[PW-1:XLEN-1];
  assign rem_diff = rem_sh - {1'b0, opnd_q};
  assign div_step = rem_diff[XLEN] ? {rem_sh[XLEN-1:0],   acc_q[XLEN-2:0], 1'b0}
                                   : {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  logic [PW-1:0] acc_nx;
  assign acc_nx = op_q[2] ? div_step : mul_step;

  // Sign fix-up and result selection from the state after the last iteration.
  logic [PW-1:0]   prod_fix;
  logic [XLEN-1:0] quot, rem, fin;

  always_comb begin
    prod_fix = (sa_q ^ sb_q) ? (~acc_nx + PW'(1)) : acc_nx;
    quot     = acc_nx[XLEN-1:0];
    rem      = acc_nx[PW-1:XLEN];
    fin      = rem;
    case (op_q)
      OP_MUL:                       fin = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin = prod_fix[PW-1:XLEN];
      OP_DIV:                       fin = (sa_q ^ sb_q) ? (~quot + XLEN'(1)) : quot;
      OP_DIVU:                      fin = quot;
      OP_REM:                       fin = sa_q ? (~rem + XLEN'(1)) : rem;
      default:                      fin = rem;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    res_d   = res_q;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          op_d   = bus.funct3;
          sa_d   = a_neg;
          sb_d   = b_neg;
          cnt_d  = '0;
          opnd_d = is_div_in ? b_abs : a_abs;
          acc_d  = {{XLEN{1'b0}}, (is_div_in ? a_abs : b_abs)};
          if (div_zero) begin
            state_d = DONE;
            res_d   = bus.funct3[1] ? bus.rs1_reg : '1;
          end else if (div_ovf) begin
            state_d = DONE;
            res_d   = bus.funct3[1] ? '0 : bus.rs1_reg;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          acc_d = acc_nx;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(XLEN - 1)) begin
            state_d = DONE;
            res_d   = fin;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_d = (state_d != IDLE);
  assign done_d = (state_d == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      opnd_q  <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      res_q   <= res_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed checks of muldiv_unit against a 64-bit arithmetic reference model.
module tb_muldiv_unit;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] SMIN = 32'h8000_0000;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  muldiv_if #(.XLEN(XLEN)) bus ();

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: RV32M semantics evaluated with 64-bit integer arithmetic.
  function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    p  = 0;
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == SMIN && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == SMIN && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 0 || (!f3[0] && a == SMIN && b == 32'hFFFF_FFFF))) return 2;
    return XLEN + 2;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return SMIN;
      3:       return 32'($urandom_range(0, 20));
      4:       return 32'h0 - 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op from an idle unit; lat is the inclusive cycle count start..done, -1 on timeout.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    int k;
    for (int w = 0; w < 100 && bus.busy; w++) step();
    bus.funct3  = f3;
    bus.rs1_reg = a;
    bus.rs2_reg = b;
    bus.start   = 1'b1;
    k   = 1;
    lat = -1;
    res = 32'h0;
    while (k < 100) begin
      step();
      k++;
      bus.start   = 1'b0;
      bus.rs1_reg = $urandom;
      bus.rs2_reg = $urandom;
      bus.funct3  = 3'($urandom);
      if (bus.done) begin
        lat = k;
        res = bus.result;
        break;
      end
    end
  endtask

  // Start an op and advance to cycle target_k (start cycle is k=1); reports any done seen.
  task automatic start_to(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input int target_k, output int dones);
    bus.funct3  = f3;
    bus.rs1_reg = a;
    bus.rs2_reg = b;
    bus.start   = 1'b1;
    dones = 0;
    for (int k = 2; k <= target_k; k++) begin
      step();
      bus.start = 1'b0;
      if (bus.done) dones++;
    end
  endtask

  typedef struct {
    string       tag;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] res;
  logic [31:0] held;
  int          lat;
  int          dones;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.flush   = 1'b0;
    bus.funct3  = 3'd0;
    bus.rs1_reg = 32'h0;
    bus.rs2_reg = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    check("reset_busy",   32'(bus.busy), 32'd0);
    check("reset_done",   32'(bus.done), 32'd0);
    check("reset_result", bus.result,    32'd0);

    vecs.push_back('{"mul_7x-3",    3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34});
    vecs.push_back('{"mulhu_max",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34});
    vecs.push_back('{"mulh_-2x3",   3'd1, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 34});
    vecs.push_back('{"mulhsu_-1",   3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34});
    vecs.push_back('{"div_-7_2",    3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 34});
    vecs.push_back('{"rem_-7_2",    3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 34});
    vecs.push_back('{"divu_100_7",  3'd5, 32'd100,      32'd7,        32'd14,        34});
    vecs.push_back('{"remu_100_7",  3'd7, 32'd100,      32'd7,        32'd2,         34});
    vecs.push_back('{"div_5_0",     3'd4, 32'd5,        32'd0,        32'hFFFF_FFFF, 2});
    vecs.push_back('{"remu_5_0",    3'd7, 32'd5,        32'd0,        32'd5,         2});
    vecs.push_back('{"div_ovf",     3'd4, SMIN,         32'hFFFF_FFFF, SMIN,         2});
    vecs.push_back('{"rem_ovf",     3'd6, SMIN,         32'hFFFF_FFFF, 32'd0,        2});

    foreach (vecs[i]) begin
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, res, lat);
      check({vecs[i].tag, "_result"},  res,      vecs[i].exp);
      check({vecs[i].tag, "_latency"}, 32'(lat), 32'(vecs[i].lat));
    end

    // Result holds and done stays low with no new request.
    repeat (5) step();
    check("hold_done",   32'(bus.done), 32'd0);
    check("hold_result", bus.result,    32'd0);

    for (int n = 0; n < 60; n++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      f3 = 3'($urandom);
      a  = pick();
      b  = pick();
      run_op(f3, a, b, res, lat);
      check($sformatf("rand%0d_f%0d_result", n, f3), res,      ref_op(f3, a, b));
      check($sformatf("rand%0d_f%0d_latency", n, f3), 32'(lat), 32'(ref_lat(f3, a, b)));
    end

    // Flush at counter 10, then an immediate new request.
    run_op(3'd0, 32'd3, 32'd5, res, lat);
    check("pre_flush_result", res, 32'd15);
    step();
    start_to(3'd5, 32'd1000, 32'd3, 12, dones);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("flush_busy",   32'(bus.busy), 32'd0);
    check("flush_done",   32'(bus.done | (dones != 0)), 32'd0);
    check("flush_result", bus.result,    32'd15);
    run_op(3'd1, 32'h1234_5678, 32'h8765_4321, res, lat);
    check("after_flush_result",  res,      ref_op(3'd1, 32'h1234_5678, 32'h8765_4321));
    check("after_flush_latency", 32'(lat), 32'd34);

    // Flush with no restart: done must never appear.
    step();
    held = bus.result;
    start_to(3'd4, 32'hFFFF_F000, 32'd7, 12, dones);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus.done) dones++;
      step();
    end
    check("flush_idle_dones",  32'(dones),  32'd0);
    check("flush_idle_result", bus.result,  held);

    // Start held high through DONE: one done, next op only after IDLE.
    bus.funct3  = 3'd5;
    bus.rs1_reg = 32'd999;
    bus.rs2_reg = 32'd10;
    bus.start   = 1'b1;
    dones = 0;
    lat   = -1;
    for (int k = 2; k <= 60; k++) begin
      step();
      if (bus.done) begin
        dones++;
        if (lat < 0) begin
          lat = k;
          res = bus.result;
        end
      end
      if (k == 35) check("held_busy_idle", 32'(bus.busy), 32'd0);
      if (k == 36) check("held_busy_next", 32'(bus.busy), 32'd1);
    end
    bus.start = 1'b0;
    check("held_dones",   32'(dones), 32'd1);
    check("held_latency", 32'(lat),   32'd34);
    check("held_result",  res,        32'd99);
    lat = -1;
    for (int k = 61; k < 120; k++) begin
      step();
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    check("held_second_done_cycle", 32'(lat), 32'd68);
    check("held_second_result",     bus.result, 32'd99);

    // Asynchronous reset mid-operation.
    step();
    start_to(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 10, dones);
    rst_n = 1'b0;
    #1;
    check("midrst_busy",   32'(bus.busy), 32'd0);
    check("midrst_done",   32'(bus.done), 32'd0);
    check("midrst_result", bus.result,    32'd0);
    step();
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus.done) dones++;
    end
    check("midrst_no_done", 32'(dones),   32'd0);
    check("midrst_idle",    32'(bus.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
